// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit BCD to 7-segment driver with a shadow register.
// It also supports optional leading-zero blanking and selectable output polarity.
`timescale 1ns/1ps
module seg7_mux_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam logic POL = (ACTIVE_LOW != 0);

  logic [4*NUM_DIGITS-1:0] bcd_sh_r;
  logic [NUM_DIGITS-1:0]   dp_sh_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;

  logic [3:0]            cur_s;
  logic                  cur_dp_s;
  logic                  cur_blank_s;
  logic                  upper_zero_s;
  logic [6:0]            seg_s;
  logic [NUM_DIGITS-1:0] an_s;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Shadow capture of the displayed value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_sh_r <= '0;
      dp_sh_r  <= '0;
    end else if (load) begin
      bcd_sh_r <= bcd_in;
      dp_sh_r  <= dp_in;
    end
  end

  // Refresh counter and digit scan index; both hold while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (enable) begin
      if (cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
        cnt_r <= '0;
        idx_r <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Select current digit; scan from the top so upper_zero_s covers digits above k
  always_comb begin
    cur_s        = 4'd0;
    cur_dp_s     = 1'b0;
    cur_blank_s  = 1'b0;
    upper_zero_s = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (IDX_W'(k) == idx_r) begin
        cur_s       = bcd_sh_r[4*k +: 4];
        cur_dp_s    = dp_sh_r[k];
        cur_blank_s = upper_zero_s && (bcd_sh_r[4*k +: 4] == 4'd0) && (k != 0);
      end else begin
        cur_blank_s = cur_blank_s;
      end
      upper_zero_s = upper_zero_s && (bcd_sh_r[4*k +: 4] == 4'd0);
    end
  end

  // Segment pattern and one-hot enable for the selected digit
  always_comb begin
    seg_s = 7'd0;
    an_s  = NUM_DIGITS'(1) << idx_r;
    if ((BLANK_LEADING != 0) && cur_blank_s) begin
      seg_s = 7'd0;
    end else begin
      seg_s = decode(cur_s);
    end
  end

  // Output register; polarity applied only here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {NUM_DIGITS{POL}};
    end else if (enable) begin
      seg <= seg_s ^ {7{POL}};
      dp  <= cur_dp_s ^ POL;
      an  <= an_s ^ {NUM_DIGITS{POL}};
    end else begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {NUM_DIGITS{POL}};
    end
  end

  assign digit_idx = idx_r;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver: common-anode/blanking and active-high/no-blanking
// instances share stimulus and are checked against a digit-level display model.
`timescale 1ns/1ps
module tb_seg7_mux_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst, enable, load;
  logic [15:0]   bcd_in;
  logic [3:0]    dp_in;
  logic [6:0]    seg1, seg2;
  logic          dp1, dp2;
  logic [3:0]    an1, an2;
  logic [1:0]    idx1, idx2;

  seg7_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg1), .dp(dp1), .an(an1), .digit_idx(idx1));

  seg7_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(0), .BLANK_LEADING(0)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg2), .dp(dp2), .an(an2), .digit_idx(idx2));

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int en_ticks;
  logic [15:0] sh_bcd;
  logic [3:0]  sh_dp;
  logic [6:0]  seg_tab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs after an edge, from the pre-edge model state
  task automatic exp_out(input bit al, input bit bl, input bit en,
                         output logic [6:0] s, output logic d, output logic [3:0] a);
    int idx;
    int v;
    idx = (en_ticks / RD) % ND;
    if (!en) begin
      s = 7'd0; d = 1'b0; a = 4'd0;
    end else begin
      v = int'((sh_bcd >> (4 * idx)) & 16'hF);
      s = seg_tab[v];
      if (bl && idx != 0 && (sh_bcd >> (4 * idx)) == 16'd0) s = 7'd0;
      d = sh_dp[idx];
      a = 4'(1 << idx);
    end
    if (al) begin
      s = ~s; d = ~d; a = ~a;
    end
  endtask

  task automatic tick();
    logic [6:0] s1, s2;
    logic d1, d2;
    logic [3:0] a1, a2;
    exp_out(1'b1, 1'b1, enable, s1, d1, a1);
    exp_out(1'b0, 1'b0, enable, s2, d2, a2);
    @(posedge clk);
    #1;
    if (load) begin
      sh_bcd = bcd_in;
      sh_dp  = dp_in;
    end
    if (enable) en_ticks++;
    chk("seg_al", 32'(seg1), 32'(s1));
    chk("dp_al",  32'(dp1),  32'(d1));
    chk("an_al",  32'(an1),  32'(a1));
    chk("idx_al", 32'(idx1), 32'((en_ticks / RD) % ND));
    chk("seg_ah", 32'(seg2), 32'(s2));
    chk("dp_ah",  32'(dp2),  32'(d2));
    chk("an_ah",  32'(an2),  32'(a2));
    chk("idx_ah", 32'(idx2), 32'((en_ticks / RD) % ND));
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic reset_model();
    en_ticks = 0; sh_bcd = 16'd0; sh_dp = 4'd0;
  endtask

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
                7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    rst = 1'b1; enable = 1'b0; load = 1'b0; bcd_in = 16'd0; dp_in = 4'd0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg1), 32'(7'b1111111));
    chk("rst_an",  32'(an1),  32'(4'b1111));
    chk("rst_dp",  32'(dp1),  32'(1'b1));
    chk("rst_an2", 32'(an2),  32'(4'b0000));
    @(negedge clk);
    rst = 1'b0;

    // Scan 1234
    do_load(16'h1234, 4'b0000);
    enable = 1'b1;
    for (int i = 0; i < 2 * RD * ND; i++) begin
      tick();
      if (an1 == 4'b1110) chk("digit4", 32'(seg1), 32'(7'b1001100));
    end

    // Mid-scan asynchronous reset, checked with no clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    reset_model();
    chk("mid_rst_seg", 32'(seg1), 32'(7'b1111111));
    chk("mid_rst_an",  32'(an1),  32'(4'b1111));
    chk("mid_rst_dp",  32'(dp1),  32'(1'b1));
    chk("mid_rst_idx", 32'(idx1), 32'(0));
    #2;
    rst = 1'b0;
    repeat (RD * ND) tick();

    // Decode sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load(16'(v), 4'b0000);
      repeat (RD * ND) tick();
    end

    // Leading blanking
    do_load(16'h0050, 4'b0000);
    repeat (RD * ND + 2) tick();
    do_load(16'h0000, 4'b0000);
    repeat (RD * ND + 2) tick();

    // dp and enable gating
    do_load(16'h5678, 4'b0100);
    repeat (RD * ND + 2) tick();
    enable = 1'b0;
    repeat (6) tick();
    do_load(16'h4321, 4'b0001);
    enable = 1'b1;
    repeat (RD * ND) tick();

    // Load on the edge where the digit advances
    for (int i = 0; i < RD; i++) begin
      if ((en_ticks % RD) != RD - 1) tick();
    end
    do_load(16'h9999, 4'b0000);
    repeat (3) tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      load   = ($urandom_range(7) == 0);
      enable = ($urandom_range(7) != 0);
      bcd_in = 16'($urandom);
      dp_in  = 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
